// File: rtl/csa_cmd_pkg.sv
// Shared constants and state encoding for the CSA command framer.
package csa_cmd_pkg;

  localparam logic [7:0] CMD_HDR      = 8'h40;
  localparam logic [7:0] CMD_PID      = 8'h11;
  localparam logic [7:0] CMD_CW       = 8'h12;
  localparam logic [7:0] CMD_ECM_CL   = 8'h13;
  localparam logic [7:0] CMD_EMM_SD   = 8'h14;
  localparam logic [7:0] CMD_EMM_HEAD = 8'h15;

  localparam int OFF_PKG_IDX = 5;
  localparam int OFF_PKG_TOT = 7;
  localparam int HDR_LEN     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_HDR,
    ST_PAY,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/csa_cmd_ram.sv
// Simple dual-port payload buffer: port A write, port B registered read.
module csa_cmd_ram #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [7:0]        wa_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [7:0]        rb_data
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] rb_data_q;

  always_ff @(posedge clk) begin
    if (wa_en) mem[wa_addr] <= wa_data;
    rb_data_q <= mem[rb_addr];
  end

  assign rb_data = rb_data_q;

endmodule

// File: rtl/csa_cmd_framer.sv
// Frames a buffered payload into 0x40-headed command packages, one byte per cycle,
// splitting CW payloads into MAX_PAYLOAD-sized numbered packages.
module csa_cmd_framer
  import csa_cmd_pkg::*;
#(
  parameter int MAX_PAYLOAD = 56,
  parameter int GAP_CYCLES  = 4,
  parameter int ADDR_W      = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        pl_din,
  input  logic              pl_din_en,
  input  logic              req_valid,
  input  logic [7:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_len,
  output logic              req_ready,
  output logic [7:0]        con_dout,
  output logic              con_dout_en,
  output logic              done,
  output logic              err
);

  // Fixed CALC length: enough subtraction steps for the largest possible len.
  localparam int                CALC_STEPS = ((1 << ADDR_W) - 1 + MAX_PAYLOAD - 1) / MAX_PAYLOAD;
  localparam logic [ADDR_W-1:0] MAXP       = ADDR_W'(MAX_PAYLOAD);
  localparam logic [31:0]       MAX_TOTAL  = 32'(255 * MAX_PAYLOAD);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] calc_q, calc_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        tot_q, tot_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] flen, calc_sub;
  logic [15:0]       flen16;
  logic              req_bad, wr_en;
  logic [7:0]        rb_data;

  csa_cmd_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wa_en   (wr_en),
    .wa_addr (wptr_q),
    .wa_data (pl_din),
    .rb_addr (rptr_q),
    .rb_data (rb_data)
  );

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    rem_d       = rem_q;
    calc_d      = calc_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    tot_d       = tot_q;
    err_d       = 1'b0;
    req_ready   = 1'b0;
    con_dout    = 8'h00;
    con_dout_en = 1'b0;
    done        = 1'b0;
    wr_en       = 1'b0;

    flen     = (rem_q > MAXP) ? MAXP : rem_q;
    flen16   = 16'(flen);
    calc_sub = (calc_q > MAXP) ? MAXP : calc_q;
    req_bad  = (req_len == '0) || (req_len > wptr_q) ||
               ((req_cmd != CMD_CW) && (req_len > MAXP)) ||
               (32'(req_len) > MAX_TOTAL);

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        wr_en     = pl_din_en && (wptr_q != '1);
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (req_valid) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            cmd_d   = req_cmd;
            calc_d  = req_len;
            rem_d   = req_len;
            wptr_d  = '0;
            rptr_d  = '0;
            tot_d   = 8'd0;
            cnt_d   = '0;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (calc_q != '0) begin
          tot_d  = tot_q + 8'd1;
          calc_d = calc_q - calc_sub;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(CALC_STEPS - 1)) begin
          cnt_d   = '0;
          idx_d   = 8'd1;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        con_dout_en = 1'b1;
        case (cnt_q[2:0])
          3'd0:                con_dout = CMD_HDR;
          3'd1:                con_dout = cmd_q;
          3'd2:                con_dout = flen16[15:8];
          3'd3:                con_dout = flen16[7:0];
          3'(OFF_PKG_IDX):     con_dout = idx_q;
          3'(OFF_PKG_TOT):     con_dout = tot_q;
          default:             con_dout = 8'h00;
        endcase
        cnt_d = cnt_q + 1'b1;
        // Issue the first read on the last header byte to cover RAM latency.
        if (cnt_q == ADDR_W'(HDR_LEN - 1)) begin
          rptr_d  = rptr_q + 1'b1;
          cnt_d   = '0;
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        con_dout_en = 1'b1;
        con_dout    = rb_data;
        if (cnt_q == flen - 1'b1) begin
          cnt_d   = '0;
          rem_d   = rem_q - flen;
          state_d = ST_GAP;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          rptr_d = rptr_q + 1'b1;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (rem_q != '0) begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_HDR;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      rem_q   <= '0;
      calc_q  <= '0;
      cnt_q   <= '0;
      cmd_q   <= 8'h00;
      idx_q   <= 8'h00;
      tot_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rem_q   <= rem_d;
      calc_q  <= calc_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      tot_q   <= tot_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_csa_cmd_framer.sv
// Bench for csa_cmd_framer: directed table, corner sequences and random requests
// checked against a frame-level reference model.
module tb_csa_cmd_framer;

  localparam int MAXP = 56;
  localparam int GAP  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pl_din;
  logic        pl_din_en;
  logic        req_valid;
  logic [7:0]  req_cmd;
  logic [12:0] req_len;
  logic        req_ready;
  logic [7:0]  con_dout;
  logic        con_dout_en;
  logic        done;
  logic        err;

  csa_cmd_framer dut (
    .clk         (clk),
    .rst         (rst),
    .pl_din      (pl_din),
    .pl_din_en   (pl_din_en),
    .req_valid   (req_valid),
    .req_cmd     (req_cmd),
    .req_len     (req_len),
    .req_ready   (req_ready),
    .con_dout    (con_dout),
    .con_dout_en (con_dout_en),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_pass = 0;
  int         wcount = 0;
  logic [7:0] ref_mem [0:8191];

  typedef struct {
    logic [7:0] cmd;
    int         nwr;
    int         len;
    bit         exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(string name, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Buffer model: writes land at the running count until the last address is reached.
  task automatic write_bytes(int n);
    for (int i = 0; i < n; i++) begin
      pl_din_en = 1'b1;
      pl_din    = 8'($urandom);
      if (wcount < 8191) begin
        ref_mem[wcount] = pl_din;
        wcount++;
      end
      @(negedge clk);
    end
    pl_din_en = 1'b0;
  endtask

  function automatic bit model_err(logic [7:0] cmd, int len);
    return (len == 0) || (len > wcount) || (cmd != 8'h12 && len > MAXP) ||
           ((len + MAXP - 1) / MAXP > 255);
  endfunction

  task automatic issue(logic [7:0] cmd, int len, bit exp_err);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_len   = 13'(len);
    @(negedge clk);
    req_valid = 1'b0;
    chk($sformatf("req c%0h l%0d err/en/rdy", cmd, len),
        {err, con_dout_en, req_ready}, exp_err ? 3'b101 : 3'b000);
    if (!exp_err) wcount = 0;
  endtask

  // Expected byte stream built directly from the frame layout rules.
  task automatic check_stream(logic [7:0] cmd, int len);
    int t = 0;
    int tot;
    int fl;
    logic [7:0] hdr [8];
    logic [7:0] exp;
    while (!con_dout_en && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!con_dout_en) begin
      chk("start_timeout", 0, 1);
      return;
    end
    tot = (len + MAXP - 1) / MAXP;
    for (int p = 1; p <= tot; p++) begin
      fl = (len - MAXP * (p - 1) > MAXP) ? MAXP : len - MAXP * (p - 1);
      hdr[0] = 8'h40; hdr[1] = cmd; hdr[2] = 8'(fl >> 8); hdr[3] = 8'(fl);
      hdr[4] = 8'h00; hdr[5] = 8'(p); hdr[6] = 8'h00;  hdr[7] = 8'(tot);
      for (int k = 0; k < 8 + fl; k++) begin
        exp = (k < 8) ? hdr[k] : ref_mem[MAXP * (p - 1) + k - 8];
        chk($sformatf("c%0h l%0d p%0d k%0d", cmd, len, p, k),
            {con_dout_en, con_dout}, {1'b1, exp});
        @(negedge clk);
      end
      for (int g = 0; g < GAP; g++) begin
        chk($sformatf("gap p%0d g%0d", p, g), {con_dout_en, con_dout}, 0);
        @(negedge clk);
      end
    end
    chk("done/err", {done, err}, 2'b10);
    @(negedge clk);
    chk("post_done", {done, req_ready}, 2'b01);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rc;
    int         rl;
    bit         re;

    vecs[0]  = '{8'h11, 6,   6,   1'b0};
    vecs[1]  = '{8'h12, 120, 120, 1'b0};
    vecs[2]  = '{8'h12, 56,  56,  1'b0};
    vecs[3]  = '{8'h12, 57,  57,  1'b0};
    vecs[4]  = '{8'h14, 57,  57,  1'b1};
    vecs[5]  = '{8'h12, 0,   1,   1'b0};
    vecs[6]  = '{8'h11, 3,   0,   1'b1};
    vecs[7]  = '{8'h12, 0,   3,   1'b0};
    vecs[8]  = '{8'h13, 10,  11,  1'b1};
    vecs[9]  = '{8'h13, 0,   10,  1'b0};
    vecs[10] = '{8'h15, 56,  56,  1'b0};

    rst = 1'b1; pl_din = 8'h00; pl_din_en = 1'b0;
    req_valid = 1'b0; req_cmd = 8'h00; req_len = '0;
    repeat (2) @(negedge clk);
    chk("reset", {con_dout, con_dout_en, done, err, req_ready}, 12'h001);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      write_bytes(vecs[v].nwr);
      issue(vecs[v].cmd, vecs[v].len, vecs[v].exp_err);
      if (!vecs[v].exp_err) check_stream(vecs[v].cmd, vecs[v].len);
      else begin
        @(negedge clk);
        chk("err_once", {err, con_dout_en}, 0);
      end
    end

    // Reset in the middle of frame 2 payload.
    write_bytes(120);
    issue(8'h12, 120, 1'b0);
    for (int t = 0; t < 400 && !con_dout_en; t++) @(negedge clk);
    repeat (64 + GAP + 8 + 10) @(negedge clk);
    chk("mid_pay2_en", con_dout_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst", {con_dout_en, con_dout, req_ready, done, err}, 12'h004);
    @(negedge clk);

    // Reset clears the write pointer.
    write_bytes(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wcount = 0;
    write_bytes(5);
    issue(8'h11, 8, 1'b1);
    issue(8'h11, 5, 1'b0);
    check_stream(8'h11, 5);

    // Back-to-back: request held high; writes during the transfer are ignored.
    write_bytes(6);
    req_valid = 1'b1; req_cmd = 8'h11; req_len = 13'd6;
    @(negedge clk);
    chk("b2b_accept1", {req_ready, err}, 0);
    wcount = 0;
    fork
      check_stream(8'h11, 6);
      begin
        repeat (20) begin
          pl_din_en = 1'b1;
          pl_din    = 8'($urandom);
          @(negedge clk);
        end
        pl_din_en = 1'b0;
      end
    join
    write_bytes(6);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_accept2", {req_ready, con_dout_en}, 0);
    wcount = 0;
    check_stream(8'h11, 6);

    // Randomized requests against the model.
    for (int r = 0; r < 16; r++) begin
      rc = 8'h11 + 8'($urandom_range(0, 4));
      write_bytes($urandom_range(0, 150));
      rl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 200)
                                       : $urandom_range(1, wcount + 1);
      re = model_err(rc, rl);
      issue(rc, rl, re);
      if (!re) check_stream(rc, rl);
      else @(negedge clk);
    end

    // Pointer saturation and the largest transfer.
    write_bytes(8195);
    issue(8'h12, 8191, 1'b0);
    check_stream(8'h12, 8191);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
